// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller for the datapath ALU.
// Expands 4-bit op codes into one or two registered ALU control words.
// Owns the architectural flag and flip registers.
// Turns the ALU branch condition into a branch-taken strobe.
module alu_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op_code,
  output logic [8:0] alu_ctrl,
  input  logic       alu_flagout,
  input  logic       alu_flipout,
  input  logic       alu_branch,
  output logic       flag,
  output logic       flip,
  output logic       wr_en,
  output logic       wr_sel,
  output logic       branch_taken,
  output logic       busy
);

  // Op code encoding
  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpAdd   = 4'h1;
  localparam logic [3:0] OpSub   = 4'h2;
  localparam logic [3:0] OpAdc   = 4'h3;
  localparam logic [3:0] OpSbc   = 4'h4;
  localparam logic [3:0] OpInc   = 4'h5;
  localparam logic [3:0] OpDec   = 4'h6;
  localparam logic [3:0] OpSra   = 4'h7;
  localparam logic [3:0] OpSrl   = 4'h8;
  localparam logic [3:0] OpSrf   = 4'h9;
  localparam logic [3:0] OpSlf   = 4'hA;
  localparam logic [3:0] OpAddf  = 4'hB;
  localparam logic [3:0] OpAdd16 = 4'hC;
  localparam logic [3:0] OpSlf16 = 4'hD;
  localparam logic [3:0] OpBnz   = 4'hE;
  localparam logic [3:0] OpBloop = 4'hF;

  // ALU control words: [8] const-1, [7] shifter, [6:5] sub-op,
  // [4:3] branch type, [2:1] add source, [0] ignore flip.
  localparam logic [8:0] CtrlNone  = 9'h000;
  localparam logic [8:0] CtrlAdd   = 9'h001;
  localparam logic [8:0] CtrlSub   = 9'h021;
  localparam logic [8:0] CtrlAdc   = 9'h041;
  localparam logic [8:0] CtrlSbc   = 9'h061;
  localparam logic [8:0] CtrlInc   = 9'h101;
  localparam logic [8:0] CtrlDec   = 9'h121;
  localparam logic [8:0] CtrlSra   = 9'h080;
  localparam logic [8:0] CtrlSrl   = 9'h0A0;
  localparam logic [8:0] CtrlSrf   = 9'h0C0;
  localparam logic [8:0] CtrlSlf   = 9'h0E0;
  localparam logic [8:0] CtrlAddf  = 9'h007;
  localparam logic [8:0] CtrlBnz   = 9'h008;
  localparam logic [8:0] CtrlBloop = 9'h018;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StExec  = 2'd1,
    StExec2 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [8:0] alu_ctrl_q, alu_ctrl_d;
  logic       wr_sel_q, wr_sel_d;
  logic       flag_q, flag_d;
  logic       flip_q, flip_d;

  logic       accept;
  logic       two_step;
  logic       exec_any;

  // Control word for the first (or only) step of an op.
  function automatic logic [8:0] ctrl_first(input logic [3:0] op);
    logic [8:0] c;
    unique case (op)
      OpNop:   c = CtrlNone;
      OpAdd:   c = CtrlAdd;
      OpSub:   c = CtrlSub;
      OpAdc:   c = CtrlAdc;
      OpSbc:   c = CtrlSbc;
      OpInc:   c = CtrlInc;
      OpDec:   c = CtrlDec;
      OpSra:   c = CtrlSra;
      OpSrl:   c = CtrlSrl;
      OpSrf:   c = CtrlSrf;
      OpSlf:   c = CtrlSlf;
      OpAddf:  c = CtrlAddf;
      OpAdd16: c = CtrlAdd;
      OpSlf16: c = CtrlSlf;
      OpBnz:   c = CtrlBnz;
      OpBloop: c = CtrlBloop;
      default: c = CtrlNone;
    endcase
    return c;
  endfunction

  // Second step: ADD16 chains the carry through ADC, SLF16 repeats the shift.
  function automatic logic [8:0] ctrl_second(input logic [3:0] op);
    logic [8:0] c;
    c = CtrlNone;
    if (op == OpAdd16) begin
      c = CtrlAdc;
    end else if (op == OpSlf16) begin
      c = CtrlSlf;
    end
    return c;
  endfunction

  function automatic logic is_two_step(input logic [3:0] op);
    return (op == OpAdd16) || (op == OpSlf16);
  endfunction

  function automatic logic writes_result(input logic [3:0] op);
    return (op != OpNop) && (op != OpBnz) && (op != OpBloop);
  endfunction

  // Only subtracting ops report a meaningful flip (srcA sign).
  function automatic logic captures_flip(input logic [3:0] op);
    return (op == OpSub) || (op == OpSbc) || (op == OpDec);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OpBnz) || (op == OpBloop);
  endfunction

  assign two_step = is_two_step(op_q);
  assign exec_any = (state_q == StExec) || (state_q == StExec2);

  // Handshake and per-cycle outputs decoded from state and latched op.
  always_comb begin
    op_ready     = 1'b0;
    wr_en        = 1'b0;
    branch_taken = 1'b0;
    unique case (state_q)
      StIdle:  op_ready = 1'b1;
      StExec:  op_ready = ~two_step;
      StExec2: op_ready = 1'b1;
      default: op_ready = 1'b0;
    endcase
    if (exec_any) begin
      wr_en = writes_result(op_q);
    end
    if (state_q == StExec) begin
      branch_taken = is_branch(op_q) & alu_branch;
    end
  end

  assign accept = op_valid & op_ready;

  // Next state, control word loading and flag/flip capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    alu_ctrl_d = alu_ctrl_q;
    wr_sel_d   = wr_sel_q;
    flag_d     = flag_q;
    flip_d     = flip_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (two_step) begin
          state_d = StExec2;
        end else if (accept) begin
          state_d = StExec;
        end else begin
          state_d = StIdle;
        end
      end
      StExec2: begin
        state_d = accept ? StExec : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      op_d       = op_code;
      alu_ctrl_d = ctrl_first(op_code);
      wr_sel_d   = 1'b0;
    end else if ((state_q == StExec) && two_step) begin
      alu_ctrl_d = ctrl_second(op_q);
      wr_sel_d   = 1'b1;
    end else if (state_d == StIdle) begin
      alu_ctrl_d = CtrlNone;
      wr_sel_d   = 1'b0;
    end

    // Capture happens at the same edge as a possible accept, so the next op
    // already sees the updated flag in its own exec cycle.
    if (wr_en) begin
      flag_d = alu_flagout;
    end
    if ((state_q == StExec) && captures_flip(op_q)) begin
      flip_d = alu_flipout;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= OpNop;
      alu_ctrl_q <= CtrlNone;
      wr_sel_q   <= 1'b0;
      flag_q     <= 1'b0;
      flip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      alu_ctrl_q <= alu_ctrl_d;
      wr_sel_q   <= wr_sel_d;
      flag_q     <= flag_d;
      flip_q     <= flip_d;
    end
  end

  assign alu_ctrl = alu_ctrl_q;
  assign wr_sel   = wr_sel_q;
  assign flag     = flag_q;
  assign flip     = flip_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer.
module tb_alu_sequencer;

  logic       clk;
  logic       reset_n;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_code;
  logic [8:0] alu_ctrl;
  logic       alu_flagout;
  logic       alu_flipout;
  logic       alu_branch;
  logic       flag;
  logic       flip;
  logic       wr_en;
  logic       wr_sel;
  logic       branch_taken;
  logic       busy;

  int n_pass;
  int n_total;

  alu_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .alu_ctrl     (alu_ctrl),
    .alu_flagout  (alu_flagout),
    .alu_flipout  (alu_flipout),
    .alu_branch   (alu_branch),
    .flag         (flag),
    .flip         (flip),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .branch_taken (branch_taken),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic       fo;
    logic       fi;
    logic       br;
    logic [8:0] ctrl;
    logic       wr;
    logic       bt;
    logic       flag_after;
    logic       flip_after;
  } vec_t;

  localparam int NumVec = 16;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // op, flagout, flipout, branch, ctrl, wr_en, branch_taken, flag after, flip after
    // Flag/flip start at 0 after reset and evolve through the table in order.
    vecs[0]  = '{4'h0, 1'b1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'h1, 1'b1, 1'b1, 1'b0, 9'h001, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'h2, 1'b0, 1'b1, 1'b0, 9'h021, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{4'h3, 1'b1, 1'b0, 1'b0, 9'h041, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{4'h4, 1'b1, 1'b0, 1'b0, 9'h061, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'h5, 1'b0, 1'b1, 1'b0, 9'h101, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'h6, 1'b1, 1'b1, 1'b0, 9'h121, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{4'h7, 1'b0, 1'b0, 1'b0, 9'h080, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{4'h8, 1'b1, 1'b0, 1'b0, 9'h0A0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{4'h9, 1'b0, 1'b0, 1'b0, 9'h0C0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'hA, 1'b1, 1'b0, 1'b0, 9'h0E0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{4'hB, 1'b0, 1'b0, 1'b0, 9'h007, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{4'hE, 1'b1, 1'b0, 1'b1, 9'h008, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{4'hF, 1'b1, 1'b0, 1'b1, 9'h018, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{4'hF, 1'b1, 1'b0, 1'b0, 9'h018, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{4'h6, 1'b0, 1'b0, 1'b0, 9'h121, 1'b1, 1'b0, 1'b0, 1'b0};

    n_pass      = 0;
    n_total     = 0;
    reset_n     = 1'b0;
    op_valid    = 1'b0;
    op_code     = 4'h0;
    alu_flagout = 1'b0;
    alu_flipout = 1'b0;
    alu_branch  = 1'b0;

    // Reset then idle
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("rst_ctrl", 16'(alu_ctrl), 16'h000);
    check("rst_flag", 16'(flag), 16'h0);
    check("rst_flip", 16'(flip), 16'h0);
    check("rst_wr_en", 16'(wr_en), 16'h0);
    check("rst_wr_sel", 16'(wr_sel), 16'h0);
    check("rst_bt", 16'(branch_taken), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_ready", 16'(op_ready), 16'h1);

    // Single ops from idle, one at a time
    for (int i = 0; i < NumVec; i++) begin
      op_valid = 1'b1;
      op_code  = vecs[i].op;
      tick();
      op_valid    = 1'b0;
      op_code     = 4'h0;
      alu_flagout = vecs[i].fo;
      alu_flipout = vecs[i].fi;
      alu_branch  = vecs[i].br;
      #1;
      check($sformatf("v%0d_ctrl", i), 16'(alu_ctrl), 16'(vecs[i].ctrl));
      check($sformatf("v%0d_wr_en", i), 16'(wr_en), 16'(vecs[i].wr));
      check($sformatf("v%0d_bt", i), 16'(branch_taken), 16'(vecs[i].bt));
      check($sformatf("v%0d_ready", i), 16'(op_ready), 16'h1);
      check($sformatf("v%0d_busy", i), 16'(busy), 16'h1);
      tick();
      check($sformatf("v%0d_flag", i), 16'(flag), 16'(vecs[i].flag_after));
      check($sformatf("v%0d_flip", i), 16'(flip), 16'(vecs[i].flip_after));
      check($sformatf("v%0d_idle_ctrl", i), 16'(alu_ctrl), 16'h000);
      check($sformatf("v%0d_idle_busy", i), 16'(busy), 16'h0);
      alu_branch = 1'b0;
    end

    // Back-to-back ADD, SUB, SLF; flip set by SUB (starts at 0 here)
    alu_flagout = 1'b0;
    alu_flipout = 1'b0;
    op_valid    = 1'b1;
    op_code     = 4'h1;
    tick();
    op_code = 4'h2;
    #1;
    check("b2b_add_ctrl", 16'(alu_ctrl), 16'h001);
    check("b2b_add_wr", 16'(wr_en), 16'h1);
    check("b2b_add_ready", 16'(op_ready), 16'h1);
    tick();
    op_code     = 4'hA;
    alu_flipout = 1'b1;
    #1;
    check("b2b_sub_ctrl", 16'(alu_ctrl), 16'h021);
    check("b2b_sub_wr", 16'(wr_en), 16'h1);
    tick();
    op_valid    = 1'b0;
    alu_flipout = 1'b0;
    #1;
    check("b2b_slf_ctrl", 16'(alu_ctrl), 16'h0E0);
    check("b2b_slf_wr", 16'(wr_en), 16'h1);
    check("b2b_flip", 16'(flip), 16'h1);
    tick();
    check("b2b_idle", 16'(busy), 16'h0);

    // ADD16 with carry out of step 1, ADC held valid (stalled) during step 1
    op_valid = 1'b1;
    op_code  = 4'hC;
    tick();
    op_code     = 4'h3;
    alu_flagout = 1'b1;
    #1;
    check("a16_s1_ctrl", 16'(alu_ctrl), 16'h001);
    check("a16_s1_sel", 16'(wr_sel), 16'h0);
    check("a16_s1_ready", 16'(op_ready), 16'h0);
    check("a16_s1_wr", 16'(wr_en), 16'h1);
    check("a16_s1_flag", 16'(flag), 16'h0);
    tick();
    alu_flagout = 1'b0;
    #1;
    check("a16_s2_ctrl", 16'(alu_ctrl), 16'h041);
    check("a16_s2_sel", 16'(wr_sel), 16'h1);
    check("a16_s2_flag", 16'(flag), 16'h1);
    check("a16_s2_ready", 16'(op_ready), 16'h1);
    check("a16_s2_wr", 16'(wr_en), 16'h1);
    tick();
    op_valid    = 1'b0;
    op_code     = 4'h0;
    alu_flagout = 1'b1;
    #1;
    check("stall_adc_ctrl", 16'(alu_ctrl), 16'h041);
    check("stall_adc_sel", 16'(wr_sel), 16'h0);
    check("stall_adc_flag", 16'(flag), 16'h0);
    check("stall_adc_busy", 16'(busy), 16'h1);
    tick();
    check("stall_done_busy", 16'(busy), 16'h0);
    check("stall_done_flag", 16'(flag), 16'h1);

    // BNZ taken strobe lasts exactly one cycle with branch held high
    op_valid = 1'b1;
    op_code  = 4'hE;
    tick();
    op_valid   = 1'b0;
    alu_branch = 1'b1;
    #1;
    check("bnz_bt", 16'(branch_taken), 16'h1);
    check("bnz_wr", 16'(wr_en), 16'h0);
    tick();
    check("bnz_bt_after", 16'(branch_taken), 16'h0);
    alu_branch = 1'b0;

    // SLF16 aborted by reset during step 2 (flag is 1 going in)
    alu_flagout = 1'b1;
    op_valid    = 1'b1;
    op_code     = 4'hD;
    tick();
    op_valid = 1'b0;
    #1;
    check("s16_s1_ctrl", 16'(alu_ctrl), 16'h0E0);
    check("s16_s1_ready", 16'(op_ready), 16'h0);
    tick();
    reset_n = 1'b0;
    #1;
    check("s16_s2_ctrl", 16'(alu_ctrl), 16'h0E0);
    check("s16_s2_sel", 16'(wr_sel), 16'h1);
    check("s16_s2_flag", 16'(flag), 16'h1);
    tick();
    reset_n = 1'b1;
    #1;
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_wr", 16'(wr_en), 16'h0);
    check("abort_flag", 16'(flag), 16'h0);
    check("abort_ctrl", 16'(alu_ctrl), 16'h000);
    check("abort_sel", 16'(wr_sel), 16'h0);
    check("abort_ready", 16'(op_ready), 16'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the datapath ALU. It accepts 4-bit operation codes over a valid/ready handshake and expands each one into one or two cycles of 9-bit ALU control words. It owns the architectural overflow-flag and flip registers, capturing them from the ALU outputs, and it qualifies the ALU branch condition into a branch-taken strobe. It sits between instruction decode and the ALU/register-file write port.

## Interface
- No parameters; all widths fixed.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `op_valid` in 1: `op_code` is valid this cycle.
- `op_ready` out 1: sequencer accepts an op this cycle.
- `op_code` in 4: operation, encoding in Operation.
- `alu_ctrl` out 9: registered ALU control word.
- `alu_flagout` in 1: ALU overflow/carry result.
- `alu_flipout` in 1: ALU flip result (srcA sign).
- `alu_branch` in 1: ALU branch condition.
- `flag` out 1: flag register; drives ALU flagin.
- `flip` out 1: flip register; drives ALU flipin.
- `wr_en` out 1: write ALU result this cycle.
- `wr_sel` out 1: 0 = low/single byte, 1 = high byte of 16-bit op.
- `branch_taken` out 1: branch op executing and condition true.
- `busy` out 1: state != IDLE.

## Operation
- ALU control fields: [8] const-1 source; [7] shifter select; [6:5] sub-op (adder: [6] take flag, [5] subtract; shifter: 00 sra, 01 srl, 10 srf, 11 slf); [4:3] branch type; [2:1] add source; [0] ignore flip.
- The op map is op (hex) -> control word(s), write:
  - 0 NOP -> 0x000, no write.
  - 1 ADD -> 0x001. 2 SUB -> 0x021. 3 ADC -> 0x041. 4 SBC -> 0x061.
  - 5 INC -> 0x101. 6 DEC -> 0x121.
  - 7 SRA -> 0x080. 8 SRL -> 0x0A0. 9 SRF -> 0x0C0. A SLF -> 0x0E0.
  - B ADDF -> 0x007.
  - C ADD16 -> 0x001 (wr_sel 0), then 0x041 (wr_sel 1).
  - D SLF16 -> 0x0E0 (wr_sel 0), then 0x0E0 (wr_sel 1).
  - E BNZ -> 0x008, no write.
  - F BLOOP -> 0x018, no write.
- All 16 codes are legal.
- FSM states are IDLE, EXEC, and EXEC2.
  - Accept = `op_valid & op_ready`.
  - IDLE: on accept, go to EXEC.
  - EXEC: for op C/D, go to EXEC2. Otherwise, go to EXEC on accept, else IDLE.
  - EXEC2: go to EXEC on accept, else IDLE.
- `op_ready` = IDLE, or EXEC of a single-step op, or EXEC2. This allows back-to-back single-step ops at 1 per cycle.
- `alu_ctrl`, `wr_sel`, and the latched op register are loaded at the accept edge (first step) or at the EXEC->EXEC2 edge (second step).
- `wr_en` = 1 in EXEC/EXEC2 for ops 1–D; 0 for ops 0, E, F and in IDLE.
- `flag` captures `alu_flagout` at the end of every cycle where `wr_en` = 1. The step-2 ADC of ADD16 therefore consumes the carry from step 1.
- `flip` captures `alu_flipout` at the end of EXEC for ops 2, 4, 6 only. It is otherwise held.
- `branch_taken` = EXEC & op ∈ {E, F} & `alu_branch`. It is combinational and valid only in that cycle.
- In IDLE, `alu_ctrl` is forced to 0x000.

## Timing
- Reset (`reset_n` = 0 at an edge): state IDLE, `alu_ctrl` 0x000, `flag` 0, `flip` 0. `wr_en`, `wr_sel`, `branch_taken`, and `busy` all deassert. `op_ready` = 1 from the first cycle after reset.
- Reset overrides everything, including an in-flight EXEC2. The second step is abandoned with no write and no flag update.
- Latency: an op accepted at edge N executes in cycle N+1. Flag/flip are visible from edge N+2. The second step of C/D runs in cycle N+2.
- `op_valid` held with `op_ready` = 0 (EXEC step 1 of C/D) must not be consumed. `op_code` may change while not ready and is sampled only on accept.
- Accept during the final exec cycle takes effect at the same edge as flag capture. The next op sees the updated `flag` in its EXEC cycle.
- NOP consumes one EXEC cycle, produces no write, and does not change `flag` or `flip`.

## Test plan
- Reset then idle: `reset_n` low 2 cycles -> all outputs 0, `op_ready` = 1, `alu_ctrl` = 0x000.
- Back-to-back ops: 1, 2, A on consecutive cycles with `alu_flipout` = 1 during SUB.
  - `alu_ctrl` = 0x001, 0x021, 0x0E0 in the three cycles after each accept.
  - `wr_en` = 1 continuously.
  - `flip` = 1 after SUB.
- ADD16 with `alu_flagout` = 1 in step 1:
  - `alu_ctrl` 0x001 then 0x041; `wr_sel` 0 then 1.
  - `op_ready` = 0 in step 1.
  - `flag` = 1 during step 2.
- Branches:
  - BNZ with `alu_branch` = 1 -> `branch_taken` = 1 for exactly one cycle, `wr_en` = 0.
  - BLOOP with `alu_branch` = 0 -> `branch_taken` stays 0.
- Reset mid-op: SLF16 accepted, `reset_n` low during EXEC2 -> next cycle IDLE, `wr_en` 0, `flag` 0.
- Stall: `op_valid` held with op 3 while ADD16 is in step 1 -> op 3 accepted only at the EXEC2 cycle and executes with `alu_ctrl` = 0x041.
